alu_complex_mc: RTL and testbench



---
 rtl/alu_complex_pkg.sv | 22 ++
 rtl/alu_iter_core.sv | 104 ++++++++++
 rtl/alu_complex_mc.sv | 148 ++++++++++++++
 tb/tb_alu_complex_mc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_complex_pkg.sv
// Shared encodings for the multi-cycle complex ALU.
package alu_complex_pkg;

    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_MOD = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Ops that need the iterative engine (one bit per cycle).
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared shift/add-subtract engine: shift-add multiply or restoring divide,
// one bit per cycle for WIDTH cycles after a start pulse.
module alu_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] prod
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    // acc: product (MUL) or partial remainder (DIV)
    // sr:  multiplier shifting right (MUL) or dividend->quotient shifting left (DIV)
    // dv:  multiplicand shifting left (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   eng_x, eng_y, eng_sum;
    logic             q_bit;

    // Single adder/subtractor shared by both modes.
    always_comb begin
        if (div_q) begin
            eng_x = {acc_q, sr_q[WIDTH-1]};
            eng_y = {1'b0, dv_q};
        end else begin
            eng_x = {1'b0, acc_q};
            eng_y = sr_q[0] ? {1'b0, dv_q} : '0;
        end
        eng_sum = div_q ? (eng_x - eng_y) : (eng_x + eng_y);
        // No borrow means the shifted remainder covered the divisor.
        q_bit   = ~eng_sum[WIDTH];
    end

    // Iteration control and datapath next state.
    always_comb begin
        acc_d    = acc_q;
        sr_d     = sr_q;
        dv_d     = dv_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        div_d    = div_q;
        done     = 1'b0;
        if (start) begin
            acc_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
            div_d    = mode_div;
            sr_d     = mode_div ? op_a : op_b;
            dv_d     = mode_div ? op_b : op_a;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                acc_d = q_bit ? eng_sum[WIDTH-1:0] : eng_x[WIDTH-1:0];
                sr_d  = {sr_q[WIDTH-2:0], q_bit};
            end else begin
                acc_d = eng_sum[WIDTH-1:0];
                sr_d  = sr_q >> 1;
                dv_d  = dv_q << 1;
            end
            // Pulse on the edge that performs the final iteration.
            if (cnt_d == CNT_W'(WIDTH)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    // Engine state registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q    <= '0;
            sr_q     <= '0;
            dv_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            dv_q     <= dv_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            div_q    <= div_d;
        end
    end

    assign quo  = sr_q;
    assign rem  = acc_q;
    assign prod = acc_q;

endmodule

// File: rtl/alu_complex_mc.sv
// Multi-cycle complex ALU: one op in flight, tagged result, valid/ready on both sides.
module alu_complex_mc
    import alu_complex_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;
    logic             iter_q, iter_d;

    logic             core_start, core_done;
    logic [WIDTH-1:0] core_quo, core_rem, core_prod, core_res;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] shift_res;

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (core_start),
        .mode_div (op != OP_MUL),
        .op_a     (src_a),
        .op_b     (src_b),
        .done     (core_done),
        .quo      (core_quo),
        .rem      (core_rem),
        .prod     (core_prod)
    );

    // Barrel shifter on the live request; captured into result_q on accept.
    always_comb begin
        shamt = src_b[SH_W-1:0];
        unique case (op)
            OP_SHL:  shift_res = src_a << shamt;
            OP_SHR:  shift_res = src_a >> shamt;
            OP_SRA:  shift_res = (src_a >> shamt) |
                                 (src_a[WIDTH-1] ? ~({WIDTH{1'b1}} >> shamt) : '0);
            default: shift_res = '0;
        endcase
    end

    // FSM next state, request capture and special-case result selection.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        result_d   = result_q;
        dbz_d      = dbz_q;
        ill_d      = ill_q;
        iter_d     = iter_q;
        core_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d     = op;
                    tag_d    = in_tag;
                    result_d = '0;
                    dbz_d    = 1'b0;
                    ill_d    = 1'b0;
                    iter_d   = 1'b0;
                    state_d  = StDone;
                    if (is_iter_op(op)) begin
                        if (op != OP_MUL && src_b == '0) begin
                            dbz_d    = 1'b1;
                            result_d = (op == OP_DIV) ? '1 : src_a;
                        end else begin
                            core_start = 1'b1;
                            iter_d     = 1'b1;
                            state_d    = StBusy;
                        end
                    end else if (op == OP_SHL || op == OP_SHR || op == OP_SRA) begin
                        result_d = shift_res;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (core_done) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // All control and output state, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            tag_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
            iter_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
            iter_q   <= iter_d;
        end
    end

    // The engine registers hold their final value until the next start,
    // so iterative results are read straight from them while in DONE.
    always_comb begin
        if (op_q == OP_MUL)      core_res = core_prod;
        else if (op_q == OP_DIV) core_res = core_quo;
        else                     core_res = core_rem;
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign result      = (out_valid && iter_q) ? core_res : result_q;
    assign out_tag     = tag_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_complex_mc.sv
// Directed and randomized checks of alu_complex_mc against an arithmetic reference.
module tb_alu_complex_mc;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [2:0]    op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [TW-1:0] out_tag;
    logic          div_by_zero;
    logic          illegal_op;

    int errors = 0;
    int checks = 0;

    alu_complex_mc #(
        .WIDTH (W),
        .TAG_W (TW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .op          (op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .out_tag     (out_tag),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns {illegal_op, div_by_zero, result}.
    function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         dz;
        logic         il;
        int unsigned  sh;
        r  = '0;
        dz = 1'b0;
        il = 1'b0;
        sh = b % W;
        case (o)
            3'd1: r = a * b;
            3'd2: if (b == 0) begin r = '1; dz = 1'b1; end else r = a / b;
            3'd3: if (b == 0) begin r = a;  dz = 1'b1; end else r = a % b;
            3'd4: r = a << sh;
            3'd5: r = a >> sh;
            3'd6: r = $unsigned($signed(a) >>> sh);
            default: il = 1'b1;
        endcase
        return {il, dz, r};
    endfunction

    function automatic logic [W-1:0] rand_b();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check({name, ".ready_timeout"}, in_ready, 1);
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t);
        wait_ready(name);
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
        op       = 3'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        in_tag   = TW'($urandom);
    endtask

    // Issue one op with out_ready high; check latency, payload, and consumption.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] t, input int exp_lat);
        logic [W+1:0] m;
        int           n;
        m         = model(o, a, b);
        out_ready = 1'b1;
        issue(name, o, a, b, t);
        n = 1;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, ".latency"}, n, exp_lat);
        check({name, ".result"}, result, m[W-1:0]);
        check({name, ".tag"}, out_tag, t);
        check({name, ".flags"}, {illegal_op, div_by_zero}, m[W+1:W]);
        tick();
        check({name, ".consumed"}, out_valid, 0);
    endtask

    initial begin
        logic [W+1:0]  m;
        logic [W+1:0]  exp_q[$];
        logic [TW-1:0] tag_q[$];
        logic [W+1:0]  e;
        logic [TW-1:0] tg;
        logic          acc;
        logic          cons;
        int            bad;
        int            n;
        int            accepted;
        int            cyc;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        src_a     = '0;
        src_b     = '0;
        in_tag    = '0;
        tick();
        tick();
        check("reset.in_ready", in_ready, 1);
        check("reset.outputs", {out_valid, result, out_tag, div_by_zero, illegal_op}, 0);
        reset_n = 1'b1;
        tick();

        // Multiply latency and tag echo
        run_op("mul_basic", 3'd1, 32'h0001_0003, 32'h0002_0005, 4'h5, 33);
        check("mul_basic.const", model(3'd1, 32'h0001_0003, 32'h0002_0005), {2'b00, 32'h000B_000F});

        // Division, modulo, divide by zero
        run_op("div_100_7", 3'd2, 32'd100, 32'd7, 4'h1, 33);
        run_op("mod_100_7", 3'd3, 32'd100, 32'd7, 4'h2, 33);
        run_op("div_max_1", 3'd2, 32'hFFFF_FFFF, 32'd1, 4'h3, 33);
        run_op("div_5_0", 3'd2, 32'd5, 32'd0, 4'h4, 1);
        run_op("mod_5_0", 3'd3, 32'd5, 32'd0, 4'h6, 1);

        // Shifts and illegal ops
        run_op("shl_wrapdist", 3'd4, 32'h1, 32'h21, 4'h7, 1);
        run_op("shr_31", 3'd5, 32'h8000_0000, 32'd31, 4'h8, 1);
        run_op("sra_4", 3'd6, 32'h8000_0000, 32'd4, 4'h9, 1);
        run_op("sra_pos", 3'd6, 32'h4000_0000, 32'd3, 4'hB, 1);
        run_op("illegal_7", 3'd7, 32'h1234, 32'h5, 4'hC, 1);
        run_op("illegal_0", 3'd0, 32'h1234, 32'h5, 4'hD, 1);

        // Back-pressure: result held, new requests ignored while busy/done
        m         = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        out_ready = 1'b0;
        issue("hold", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'hA);
        bad = 0;
        n   = 1;
        while (!out_valid && n < 200) begin
            in_valid = 1'b1;
            op       = 3'($urandom_range(2, 6));
            src_b    = $urandom;
            if (in_ready) bad++;
            tick();
            n++;
        end
        check("hold.latency", n, 33);
        check("hold.busy_ready_cycles", bad, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op       = 3'd4;
            check("hold.stable", {out_valid, in_ready, out_tag, result}, {1'b1, 1'b0, 4'hA, m[W-1:0]});
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hold.consumed", {out_valid, in_ready}, 2'b01);
        tick();
        tick();
        check("hold.no_extra", out_valid, 0);

        // Reset in the middle of a division
        issue("rst_div", 3'd2, 32'd1000, 32'd3, 4'h3);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        check("rst_div.after", {out_valid, in_ready}, 2'b01);
        reset_n = 1'b1;
        repeat (40) tick();
        check("rst_div.discarded", out_valid, 0);
        run_op("mul_after_rst", 3'd1, 32'd3, 32'd4, 4'hE, 33);

        // Random stream with random handshakes, in-order scoreboard
        accepted  = 0;
        cyc       = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        while ((accepted < 2000 || exp_q.size() != 0) && cyc < 80000) begin
            @(negedge clock);
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check("rnd.unexpected_result", exp_q.size(), 1);
                end else begin
                    e  = exp_q.pop_front();
                    tg = tag_q.pop_front();
                    check("rnd.result", {illegal_op, div_by_zero, out_tag, result},
                          {e[W+1:W], tg, e[W-1:0]});
                end
            end
            if (acc) begin
                exp_q.push_back(model(op, src_a, src_b));
                tag_q.push_back(in_tag);
                accepted++;
            end
            @(posedge clock);
            #1;
            cyc++;
            if (acc || !in_valid) begin
                if (accepted < 2000 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    op       = 3'($urandom);
                    src_a    = $urandom;
                    src_b    = rand_b();
                    in_tag   = TW'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rnd.accepted", accepted, 2000);
        check("rnd.drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
